// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and FIFO entry sizing.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ISSUE    = 2'd0,
    WAIT_RES = 2'd1,
    ACK      = 2'd2,
    DRAIN    = 2'd3
  } fetch_state_t;

  // A queued entry is {pc, instr}.
  function automatic int entry_width(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, occupancy level and full/empty flags.
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level      = wr_ptr - rd_ptr;
  assign empty      = (level == '0);
  assign full       = (level == (AW + 1)'(DEPTH));
  assign head_valid = !empty;
  assign head_data  = mem[rd_ptr[AW-1:0]];

  // Flush wins over any same-cycle push or pop.
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  push_never_full : assert property (@(posedge clk) disable iff (!reset) !(push && full && !flush));

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer driving the pipeline DIR/DOR handshakes and buffering {pc, instr} results for decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          pipeline_DIR,
  output logic [ADDR_WIDTH-1:0]         pipe_data_in,
  input  logic                          ack_from_pipeline,
  input  logic                          pipeline_DOR,
  input  logic [DATA_WIDTH-1:0]         pipe_data_out,
  output logic                          ack_to_pipeline,
  output logic                          instr_valid,
  output logic [ADDR_WIDTH-1:0]         instr_pc,
  output logic [DATA_WIDTH-1:0]         instr_data,
  input  logic                          instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH);

  fetch_state_t          state_q;
  fetch_state_t          state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  issue_req;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    head;

  // Credit: only one request is ever outstanding, so a free slot now guarantees room for its result.
  assign issue_req = (state_q == ISSUE) && !fifo_full;
  assign push      = (state_q == WAIT_RES) && pipeline_DOR && !redirect_valid;
  assign pop       = instr_valid && instr_ready;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({pc_q, pipe_data_out}),
    .pop        (pop),
    .head_data  (head),
    .head_valid (instr_valid),
    .level      (fifo_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign {instr_pc, instr_data} = fifo_empty ? '0 : head;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ISSUE;
    else        state_q <= state_d;
  end

  // NOTE: state_d takes a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ISSUE:    if (issue_req && ack_from_pipeline) state_d = redirect_valid ? DRAIN : WAIT_RES;
      // A result arriving with a redirect is still acknowledged, so nothing is left to drain.
      WAIT_RES: if (pipeline_DOR)                   state_d = ACK;
                else if (redirect_valid)            state_d = DRAIN;
      ACK:                                          state_d = ISSUE;
      DRAIN:    if (pipeline_DOR)                   state_d = ACK;
      default:                                      state_d = ISSUE;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    pipeline_DIR    = 1'b0;
    ack_to_pipeline = 1'b0;
    unique case (state_q)
      ISSUE:           pipeline_DIR    = issue_req && reset;
      WAIT_RES, DRAIN: ack_to_pipeline = pipeline_DOR && reset;
      default: ;
    endcase
    pipe_data_in = pipeline_DIR ? pc_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              pc_q <= ADDR_WIDTH'(RESET_PC);
    else if (redirect_valid) pc_q <= redirect_pc;
    else if (push)           pc_q <= pc_q + 1'b1;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a pipeline model echoes PC+0x10 and the decode side is checked in order.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] data;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       ack_from = 1'b0;
  logic       dor = 1'b0;
  logic [7:0] dout = '0;
  logic       instr_ready = 1'b0;

  logic       pipeline_DIR;
  logic [7:0] pipe_data_in;
  logic       ack_to_pipeline;
  logic       instr_valid;
  logic [7:0] instr_pc;
  logic [7:0] instr_data;
  logic [2:0] fifo_level;

  entry_t     exp_q[$];
  logic [7:0] exp_pc = '0;
  logic [7:0] held_pc = '0;
  logic [7:0] last_pop_pc = '0;
  int         pstate = 0;
  int         lat = 0;
  bit         stale = 0;
  bit         ack_seen = 0;
  int         total = 0;
  int         bad = 0;
  int         n_ack = 0;
  int         n_hs = 0;
  int         n_pop = 0;

  fetch_sequencer #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .FIFO_DEPTH (4),
    .RESET_PC   (0)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .pipeline_DIR      (pipeline_DIR),
    .pipe_data_in      (pipe_data_in),
    .ack_from_pipeline (ack_from),
    .pipeline_DOR      (dor),
    .pipe_data_out     (dout),
    .ack_to_pipeline   (ack_to_pipeline),
    .instr_valid       (instr_valid),
    .instr_pc          (instr_pc),
    .instr_data        (instr_data),
    .instr_ready       (instr_ready),
    .fifo_level        (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Pipeline model drives on the falling edge; results and pops are sampled 2ns later.
  always begin
    entry_t e;
    @(negedge clk);
    if (!reset) begin
      pstate   = 0;
      ack_from = 1'b0;
      dor      = 1'b0;
    end else begin
      case (pstate)
        0: if (pipeline_DIR) begin
          check("issue_pc", pipe_data_in, exp_pc);
          held_pc  = pipe_data_in;
          ack_from = 1'b1;
          lat      = 2;
          pstate   = 1;
        end
        1: begin
          ack_from = 1'b0;
          lat--;
          if (lat == 0) begin
            dor    = 1'b1;
            dout   = held_pc + 8'h10;
            pstate = 2;
          end
        end
        2: if (ack_seen) begin
          dor    = 1'b0;
          pstate = 0;
        end
        default: pstate = 0;
      endcase
    end
    #2;
    ack_seen = 1'b0;
    if (reset) begin
      if (ack_to_pipeline) n_ack++;
      if (instr_valid && instr_ready && !redirect_valid) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("pop_unexpected", instr_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr_data", instr_data, e.data);
          last_pop_pc = instr_pc;
        end
      end
      if (dor && ack_to_pipeline) begin
        ack_seen = 1'b1;
        n_hs++;
        if (stale) begin
          stale = 0;
        end else begin
          e.pc   = exp_pc;
          e.data = exp_pc + 8'h10;
          exp_q.push_back(e);
          exp_pc = exp_pc + 8'h01;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    if (pstate != 0) stale = 1;
    exp_pc = pc;
    exp_q.delete();
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n, input string tag);
    int target;
    int k;
    target = n_pop + n;
    k = 0;
    while (n_pop < target && k < 400) begin
      step();
      k++;
    end
    check(tag, n_pop >= target, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) step();
    check("rst_dir", pipeline_DIR, 1'b0);
    check("rst_ack", ack_to_pipeline, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_data_in", pipe_data_in, 8'h00);

    // Streaming from reset with a consumer that is always ready.
    reset       = 1'b1;
    instr_ready = 1'b1;
    wait_pops(4, "p1_pops");
    check("p1_last_pc", last_pop_pc, 8'h03);
    check("p1_ack_per_result", n_ack, n_hs);

    // Stalled consumer: FIFO fills, credit stops issue, one pop reopens it.
    instr_ready = 1'b0;
    k = 0;
    while (fifo_level != 3'd4 && k < 100) begin step(); k++; end
    repeat (10) step();
    check("p2_level_full", fifo_level, 3'd4);
    check("p2_dir_blocked", pipeline_DIR, 1'b0);
    check("p2_valid", instr_valid, 1'b1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("p2_level_after_pop", fifo_level, 3'd3);
    check("p2_dir_reissue", pipeline_DIR, 1'b1);
    check("p2_reissue_pc", pipe_data_in, exp_pc);

    // PC wrap across 0xFF.
    instr_ready = 1'b1;
    do_redirect(8'hFE);
    check("p3_flush_level", fifo_level, 3'd0);
    wait_pops(3, "p3_pops");
    check("p3_wrap_pc", last_pop_pc, 8'h00);

    // Redirect during WAIT_RES with two entries queued.
    instr_ready = 1'b0;
    k = 0;
    while (!(fifo_level == 3'd2 && pstate == 1 && !ack_from) && k < 200) begin step(); k++; end
    check("p4_found_wait_res", fifo_level == 3'd2 && pstate == 1, 1'b1);
    do_redirect(8'h40);
    check("p4_flush_level", fifo_level, 3'd0);
    check("p4_flush_valid", instr_valid, 1'b0);
    instr_ready = 1'b1;
    wait_pops(1, "p4_pops");
    check("p4_first_pc", last_pop_pc, 8'h40);

    // Redirect in the same cycle as ack_from_pipeline and a pop.
    instr_ready = 1'b0;
    k = 0;
    while (!(instr_valid && ack_from) && k < 200) begin step(); k++; end
    check("p5_found_ack_pop", instr_valid && ack_from, 1'b1);
    instr_ready = 1'b1;
    do_redirect(8'h80);
    instr_ready = 1'b0;
    check("p5_flush_level", fifo_level, 3'd0);
    k = 0;
    while (!pipeline_DIR && k < 50) begin step(); k++; end
    check("p5_no_push_level", fifo_level, 3'd0);
    check("p5_issue_pc", pipe_data_in, 8'h80);

    // Reset asserted mid-WAIT_RES.
    k = 0;
    while (!(fifo_level != 3'd0 && pstate == 1 && !ack_from) && k < 200) begin step(); k++; end
    check("p6_found_wait_res", pstate == 1 && fifo_level != 3'd0, 1'b1);
    reset  = 1'b0;
    exp_pc = 8'h00;
    stale  = 0;
    exp_q.delete();
    #1;
    check("p6_dir", pipeline_DIR, 1'b0);
    check("p6_data_in", pipe_data_in, 8'h00);
    check("p6_ack", ack_to_pipeline, 1'b0);
    check("p6_valid", instr_valid, 1'b0);
    check("p6_instr_pc", instr_pc, 8'h00);
    check("p6_instr_data", instr_data, 8'h00);
    check("p6_level", fifo_level, 3'd0);
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("p6_dir_after", pipeline_DIR, 1'b1);
    check("p6_pc_after", pipe_data_in, 8'h00);
    instr_ready = 1'b1;
    wait_pops(2, "p6_pops");
    check("p6_last_pc", last_pop_pc, 8'h01);
    check("final_ack_per_result", n_ack, n_hs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
